byte_serial_add_ctrl: RTL and testbench
=======================================

Name: byte_serial_add_ctrl

Overview:
- Multi-cycle sequencer directly upstream and downstream of the team's 8-bit ripple adder.
- Accepts NBYTES-wide operands over a valid/ready handshake and drives the adder one byte per cycle, LSB first.
- Chains the adder carry between bytes, reassembles the wide result, and presents it with ALU flags over a second valid/ready handshake.
- The adder stays external; this block connects to its x, y, c inputs and s[8:0], ov outputs.

Parameters:
- NBYTES, 4, operand width in bytes; legal range 2..8; data width W = 8*NBYTES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept an operand.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- op_sub  in  1  1 = A - B (B inverted, initial carry 1); 0 = A + B.
- add_x  out  8  adder x input.
- add_y  out  8  adder y input.
- add_cin  out  1  adder carry in.
- add_s  in  9  adder sum; [8] is carry out of bit 7.
- add_c7  in  1  adder ov output, i.e. carry out of bit 6.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  sum or difference.
- carry_out  out  1  final add_s[8]; for subtract, 1 = no borrow.
- overflow  out  1  signed overflow = add_s[8] XOR add_c7, sampled on the last byte.
- zero  out  1  result == 0.
- negative  out  1  result[W-1].

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset: state=IDLE; all registers and outputs 0; in_ready=0 while rst_n low, 1 in IDLE after release.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: a_reg<=op_a; b_reg<=op_sub ? ~op_b : op_b; carry_reg<=op_sub; idx<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Combinationally: add_x=a_reg byte idx, add_y=b_reg byte idx, add_cin=carry_reg.
  - Each edge: res_reg byte idx<=add_s[7:0]; carry_reg<=add_s[8]; idx<=idx+1.
  - At idx==NBYTES-1: latch carry_out=add_s[8] and overflow=add_s[8]^add_c7; go to DONE.
- add_x, add_y, add_cin are 0 outside RUN.
- Latency: accept at edge t, bytes captured at edges t+1..t+NBYTES, out_valid high after edge t+NBYTES.
- DONE:
  - out_valid=1; result and all flags held stable until out_ready.
  - out_valid and out_ready together at an edge: go to IDLE; out_valid<=0.
  - in_ready=0 throughout DONE; no overlap.
  - Throughput: one op per NBYTES+2 cycles minimum.
- Flags zero and negative are derived combinationally from the registered result. All outputs are otherwise registered except add_x, add_y, add_cin.
- Held values: result and flags keep their last values in IDLE; out_valid=0.
- Reset mid-operation (any state): immediate return to reset values; the in-flight op is discarded with no output.
- in_valid during RUN or DONE: ignored; the upstream holds it per the handshake.
- Operand changes after acceptance: no effect.
- Wrap-around: result is the modulo 2^W sum.

Optional Feature:
- Macro: BYTE_SERIAL_ADD_SAT_EN.
- Defined:
  - If overflow=1, result is saturated to 0x7F..F when the effective A sign is 0, or 0x80..0 when it is 1.
  - Saturation is applied when entering DONE.
  - overflow and carry_out still report the raw values.
  - zero and negative reflect the saturated result.
  - Latency unchanged.
- Undefined: wrap-around result; no saturation logic.

Decomposition:
- Package bsa_pkg:
  - state enum {IDLE, RUN, DONE}.
  - BYTE_W=8.
  - default NBYTES.
  - function computing the saturation constants from the sign.
- One natural sub-module, bsa_flag_gen: combinational zero/negative/saturation from the result and overflow.
- The byte mux and FSM stay in the top module.

Test Plan:
1. NBYTES=4, add 0x000000FF+0x00000001 -> result 0x00000100, carry_out 0, overflow 0, zero 0, negative 0; out_valid exactly 4 cycles after the accept edge.
2. 0xFFFFFFFF+0x00000001 -> result 0x00000000, carry_out 1, zero 1, overflow 0.
3. 0x7FFFFFFF+0x00000001 -> result 0x80000000, overflow 1, negative 1, carry_out 0. With BYTE_SERIAL_ADD_SAT_EN: result 0x7FFFFFFF, negative 0, overflow 1.
4. op_sub=1, 0x00000005-0x00000007 -> result 0xFFFFFFFE, carry_out 0, negative 1. Then 7-5 -> 0x00000002, carry_out 1.
5. out_ready held 0 for 3 cycles in DONE with in_valid=1 and new operands -> result and flags unchanged, in_ready 0. After out_ready=1 the block returns to IDLE and accepts the new op next cycle.
6. rst_n pulsed low during the 2nd RUN byte -> all outputs 0 immediately, no out_valid. After release, 0x12345678+0x11111111 -> 0x23456789.

Source files
------------

// File: rtl/bsa_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
//   state_e   : sequencer states (IDLE, RUN, DONE)
//   BYTE_W    : width of one adder slice
//   NBYTES_DEF: default operand width in bytes
//   sat_const : signed saturation limit for a given sign and data width
// Optional feature macro: BYTE_SERIAL_ADD_SAT_EN (saturating result).
package bsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BYTE_W     = 8;
  localparam int NBYTES_DEF = 4;

  // Sign 0 saturates to the largest positive value (0x7F..F), sign 1 to the
  // most negative value (0x80..0). Callers truncate to their own width.
  function automatic logic [63:0] sat_const(input logic sign, input int width);
    logic [63:0] msb;
    msb = 64'd1 << (width - 1);
    return sign ? msb : (msb - 64'd1);
  endfunction

endpackage

// File: rtl/bsa_flag_gen.sv
// Combinational flag and saturation logic for byte_serial_add_ctrl.
// Ports:
//   raw_next    in  W  result as it will be captured on the final byte
//   ovf_next    in  1  signed overflow of the final byte
//   sign_a      in  1  sign of the effective A operand
//   sat_next    out W  result to register (saturated when enabled)
//   result      in  W  registered result
//   has_result  in  1  a result has been produced since reset
//   zero        out 1  registered result is zero
//   negative    out 1  registered result MSB
// Optional feature macro: BYTE_SERIAL_ADD_SAT_EN.
module bsa_flag_gen
  import bsa_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] raw_next,
  input  logic         ovf_next,
  input  logic         sign_a,
  output logic [W-1:0] sat_next,
  input  logic [W-1:0] result,
  input  logic         has_result,
  output logic         zero,
  output logic         negative
);

`ifdef BYTE_SERIAL_ADD_SAT_EN
  // Clamp toward the sign of A: an overflow means A and the effective B
  // shared that sign and the true result lies beyond it.
  assign sat_next = ovf_next ? W'(sat_const(sign_a, W)) : raw_next;
`else
  logic unused_sat_inputs;
  assign unused_sat_inputs = ovf_next ^ sign_a;
  assign sat_next          = raw_next;
`endif

  // Gated by has_result so every output reads 0 straight out of reset,
  // even though the cleared result register is numerically zero.
  assign zero     = has_result & ~|result;
  assign negative = result[W-1];

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial add/subtract sequencer wrapped around an external 8-bit adder.
// Accepts W = 8*NBYTES operands on a valid/ready handshake, walks the adder
// LSB byte first while chaining the carry, then presents the result and flags
// on a second valid/ready handshake.
// Ports:
//   clk, rst_n                clock, async active-low reset
//   in_valid/in_ready         operand handshake
//   op_a, op_b, op_sub        operands and subtract select
//   add_x, add_y, add_cin     to adder (0 outside RUN)
//   add_s, add_c7             from adder (sum with carry, carry out of bit 6)
//   out_valid/out_ready       result handshake
//   result, carry_out, overflow, zero, negative   result and flags
// Optional feature macro: BYTE_SERIAL_ADD_SAT_EN (saturate on overflow).
module byte_serial_add_ctrl
  import bsa_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NBYTES-1:0]    op_a,
  input  logic [8*NBYTES-1:0]    op_b,
  input  logic                   op_sub,
  output logic [BYTE_W-1:0]      add_x,
  output logic [BYTE_W-1:0]      add_y,
  output logic                   add_cin,
  input  logic [BYTE_W:0]        add_s,
  input  logic                   add_c7,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NBYTES-1:0]    result,
  output logic                   carry_out,
  output logic                   overflow,
  output logic                   zero,
  output logic                   negative
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e state_q, state_d;
  logic [NBYTES-1:0][BYTE_W-1:0] a_q, a_d;
  logic [NBYTES-1:0][BYTE_W-1:0] b_q, b_d;
  logic [NBYTES-1:0][BYTE_W-1:0] res_q, res_d;
  logic [NBYTES-1:0][BYTE_W-1:0] res_next;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic carry_out_q, carry_out_d;
  logic overflow_q, overflow_d;
  logic out_valid_q, out_valid_d;
  logic in_ready_q, in_ready_d;
  logic has_result_q, has_result_d;
  logic [W-1:0] res_final;
  logic ovf_next;

  // Current result with the byte under the adder replaced by its sum.
  always_comb begin
    res_next        = res_q;
    res_next[idx_q] = add_s[BYTE_W-1:0];
  end

  assign ovf_next = add_s[BYTE_W] ^ add_c7;

  bsa_flag_gen #(.W(W)) u_flag_gen (
    .raw_next   (res_next),
    .ovf_next   (ovf_next),
    .sign_a     (a_q[NBYTES-1][BYTE_W-1]),
    .sat_next   (res_final),
    .result     (res_q),
    .has_result (has_result_q),
    .zero       (zero),
    .negative   (negative)
  );

  // Next-state and adder drive. Subtraction is folded in at accept time by
  // storing ~B and seeding the carry with 1, so RUN never looks at op_sub.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    carry_out_d  = carry_out_q;
    overflow_d   = overflow_q;
    out_valid_d  = out_valid_q;
    has_result_d = has_result_q;
    add_x        = '0;
    add_y        = '0;
    add_cin      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = op_a;
          b_d     = op_sub ? ~op_b : op_b;
          carry_d = op_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_x   = a_q[idx_q];
        add_y   = b_q[idx_q];
        add_cin = carry_q;
        carry_d = add_s[BYTE_W];
        if (idx_q == LAST_IDX) begin
          res_d        = res_final;
          carry_out_d  = add_s[BYTE_W];
          overflow_d   = ovf_next;
          has_result_d = 1'b1;
          out_valid_d  = 1'b1;
          idx_d        = '0;
          state_d      = DONE;
        end else begin
          res_d = res_next;
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered so in_ready stays low during reset and rises on the first
    // edge after release.
    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      carry_out_q  <= 1'b0;
      overflow_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      has_result_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      carry_out_q  <= carry_out_d;
      overflow_q   <= overflow_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      has_result_q <= has_result_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Directed testbench for byte_serial_add_ctrl (NBYTES=4) with a behavioural
// model of the external 8-bit ripple adder.
// Optional feature macro: BYTE_SERIAL_ADD_SAT_EN changes expected results.
module tb_byte_serial_add_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic [7:0]   add_x;
  logic [7:0]   add_y;
  logic         add_cin;
  logic [8:0]   add_s;
  logic         add_c7;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic [7:0]   low7_sum;

  int compared   = 0;
  int mismatched = 0;

  byte_serial_add_ctrl #(.NBYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_c7    (add_c7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  // External 8-bit ripple adder model: 9-bit sum plus carry out of bit 6.
  assign add_s    = {1'b0, add_x} + {1'b0, add_y} + {8'd0, add_cin};
  assign low7_sum = {1'b0, add_x[6:0]} + {1'b0, add_y[6:0]} + {7'd0, add_cin};
  assign add_c7   = low7_sum[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation and leaves the block in DONE (out_ready held low).
  // lat returns the number of edges from accept until out_valid is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, output int lat);
    int waitc;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = '1; op_b = '1; op_sub = ~sub;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_sub = 1'b0;
    #1 rst_n = 1'b0;
    #12;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    compared++; if (result !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_result: got %h want 0", result); end
    compared++; if ({carry_out, overflow, zero, negative} !== 4'b0) begin mismatched++; $display("[TB] FAIL reset_flags: got %b want 0000", {carry_out, overflow, zero, negative}); end
    compared++; if ({add_x, add_y, add_cin} !== 17'h0) begin mismatched++; $display("[TB] FAIL reset_adder_drive: got %h want 0", {add_x, add_y, add_cin}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_basic();
    int lat;
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
    compared++; if (lat !== 4) begin mismatched++; $display("[TB] FAIL add_latency: got %0d want 4", lat); end
    compared++; if (result !== 32'h0000_0100) begin mismatched++; $display("[TB] FAIL add_result: got %h want 00000100", result); end
    compared++; if ({carry_out, overflow, zero, negative} !== 4'b0000) begin mismatched++; $display("[TB] FAIL add_flags: got %b want 0000", {carry_out, overflow, zero, negative}); end
    compared++; if ({in_ready, add_x, add_y, add_cin} !== 18'h0) begin mismatched++; $display("[TB] FAIL done_ready_drive: got %h want 0", {in_ready, add_x, add_y, add_cin}); end
    release_result();
  endtask

  task automatic test_carry_wrap();
    int lat;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    compared++; if (lat !== 4) begin mismatched++; $display("[TB] FAIL wrap_latency: got %0d want 4", lat); end
    compared++; if (result !== 32'h0) begin mismatched++; $display("[TB] FAIL wrap_result: got %h want 00000000", result); end
    compared++; if ({carry_out, overflow, zero, negative} !== 4'b1010) begin mismatched++; $display("[TB] FAIL wrap_flags: got %b want 1010", {carry_out, overflow, zero, negative}); end
    release_result();
  endtask

  task automatic test_overflow();
    int lat;
    logic [W-1:0] exp_res;
    logic         exp_neg;
`ifdef BYTE_SERIAL_ADD_SAT_EN
    exp_res = 32'h7FFF_FFFF; exp_neg = 1'b0;
`else
    exp_res = 32'h8000_0000; exp_neg = 1'b1;
`endif
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    compared++; if (result !== exp_res) begin mismatched++; $display("[TB] FAIL ovf_result: got %h want %h", result, exp_res); end
    compared++; if ({carry_out, overflow, zero, negative} !== {1'b0, 1'b1, 1'b0, exp_neg}) begin mismatched++; $display("[TB] FAIL ovf_flags: got %b want %b", {carry_out, overflow, zero, negative}, {1'b0, 1'b1, 1'b0, exp_neg}); end
    release_result();
  endtask

  task automatic test_subtract();
    int lat;
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, lat);
    compared++; if (result !== 32'hFFFF_FFFE) begin mismatched++; $display("[TB] FAIL sub_neg_result: got %h want fffffffe", result); end
    compared++; if ({carry_out, overflow, zero, negative} !== 4'b0001) begin mismatched++; $display("[TB] FAIL sub_neg_flags: got %b want 0001", {carry_out, overflow, zero, negative}); end
    release_result();
    run_op(32'h0000_0007, 32'h0000_0005, 1'b1, lat);
    compared++; if (result !== 32'h0000_0002) begin mismatched++; $display("[TB] FAIL sub_pos_result: got %h want 00000002", result); end
    compared++; if ({carry_out, overflow, zero, negative} !== 4'b1000) begin mismatched++; $display("[TB] FAIL sub_pos_flags: got %b want 1000", {carry_out, overflow, zero, negative}); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(32'h0000_0010, 32'h0000_0020, 1'b0, lat);
    op_a = 32'h0000_0001; op_b = 32'h0000_0002; op_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      compared++; if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'h0000_0030}) begin mismatched++; $display("[TB] FAIL hold_cycle%0d: got v=%b r=%b res=%h want v=1 r=0 res=00000030", i, out_valid, in_ready, result); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    compared++; if ({out_valid, in_ready} !== 2'b01) begin mismatched++; $display("[TB] FAIL return_idle: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL next_accept: got in_ready=%b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    compared++; if (lat !== 4) begin mismatched++; $display("[TB] FAIL b2b_latency: got %0d want 4", lat); end
    compared++; if (result !== 32'h0000_0003) begin mismatched++; $display("[TB] FAIL b2b_result: got %h want 00000003", result); end
    release_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    op_a = 32'hAAAA_AAAA; op_b = 32'h5555_5555; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    compared++; if ({out_valid, in_ready, carry_out, overflow, zero, negative} !== 6'b0) begin mismatched++; $display("[TB] FAIL midreset_ctrl: got %b want 000000", {out_valid, in_ready, carry_out, overflow, zero, negative}); end
    compared++; if ({result, add_x, add_y, add_cin} !== 49'h0) begin mismatched++; $display("[TB] FAIL midreset_data: got res=%h x=%h y=%h want 0", result, add_x, add_y); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    compared++; if (seen !== 0) begin mismatched++; $display("[TB] FAIL midreset_no_output: got %0d valid cycles want 0", seen); end
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
    compared++; if (lat !== 4) begin mismatched++; $display("[TB] FAIL post_reset_latency: got %0d want 4", lat); end
    compared++; if (result !== 32'h2345_6789) begin mismatched++; $display("[TB] FAIL post_reset_result: got %h want 23456789", result); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_carry_wrap();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
